// File: rtl/hw2_quotient_bcd.sv
`default_nettype none
// ============================================================================
// Module      : hw2_quotient_bcd
// Description : Downstream stage of the HW2 divider. On a 0->1 transition of
//               Done it captures Quotient and converts it to packed BCD with
//               the shift-and-add-3 (double dabble) algorithm, one bit per
//               clock. A divider overflow bypasses the conversion and is
//               reported as an all-ones BCD word with Err set.
// Ports       : Clk      - rising-edge clock
//               Rst      - asynchronous reset, active-high
//               Done     - divider completion; its rising edge starts a job
//               Overflow - divider overflow flag, sampled with Quotient
//               Quotient - divider result, sampled on the accepting edge
//               BCD      - packed BCD result, MS digit in the top nibble
//               Err      - 1 = last result was an overflow
//               Valid    - one-cycle pulse, BCD/Err just updated
//               Busy     - conversion in progress
// Revision    : 1.0 - initial release
// ============================================================================
module hw2_quotient_bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Done,
   input  logic                  Overflow,
   input  logic [WIDTH-1:0]      Quotient,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  Err,
   output logic                  Valid,
   output logic                  Busy
);

   localparam int BW = 4 * DIGITS;        // BCD field width
   localparam int SW = BW + WIDTH;        // full {bcd, bin} shift register
   localparam int CW = $clog2(WIDTH + 1); // bit counter width

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state, state_n;
   logic            done_q;
   logic            start;
   logic [CW-1:0]   cnt, cnt_n;
   logic [SW-1:0]   sr, sr_n;
   logic [BW-1:0]   bcd_n;
   logic            err_n, valid_n, busy_n;
   logic [BW-1:0]   bcd_adj;
   logic [SW-1:0]   shifted;

   // done_q resets to 1 so a Done already high at reset release is not
   // mistaken for a fresh completion.
   assign start = Done & ~done_q;

   // Add-3 correction on every BCD nibble independently (no inter-nibble
   // carry): a nibble >= 5 would become >= 10 after the shift.
   generate
      for (genvar d = 0; d < DIGITS; d++) begin : g_adj
         logic [3:0] nib;
         assign nib = sr[WIDTH + 4*d +: 4];
         assign bcd_adj[4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   // The MSB of the corrected BCD field is dropped by the shift; it is always
   // zero because 10^DIGITS exceeds the largest binary input.
   assign shifted = {bcd_adj[BW-2:0], sr[WIDTH-1:0], 1'b0};

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sr_n    = sr;
      bcd_n   = BCD;
      err_n   = Err;
      valid_n = 1'b0;
      busy_n  = Busy;
      case (state)
         IDLE: begin
            if (start) begin
               if (Overflow) begin
                  bcd_n   = '1;
                  err_n   = 1'b1;
                  valid_n = 1'b1;
               end else begin
                  sr_n    = {{BW{1'b0}}, Quotient};
                  cnt_n   = '0;
                  busy_n  = 1'b1;
                  state_n = SHIFT;
               end
            end
         end
         SHIFT: begin
            // Done rises seen here are consumed by done_q and not queued.
            sr_n  = shifted;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               bcd_n   = shifted[SW-1:WIDTH];
               err_n   = 1'b0;
               valid_n = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state  <= IDLE;
         done_q <= 1'b1;
         cnt    <= '0;
         sr     <= '0;
         BCD    <= '0;
         Err    <= 1'b0;
         Valid  <= 1'b0;
         Busy   <= 1'b0;
      end else begin
         state  <= state_n;
         done_q <= Done;
         cnt    <= cnt_n;
         sr     <= sr_n;
         BCD    <= bcd_n;
         Err    <= err_n;
         Valid  <= valid_n;
         Busy   <= busy_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hw2_quotient_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_hw2_quotient_bcd
// Description : Scoreboard bench for hw2_quotient_bcd. Stimulus pushes the
//               expected {BCD, Err} into a queue; a monitor pops and compares
//               on every Valid pulse. Expected values come from a decimal
//               digit-extraction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hw2_quotient_bcd;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;
   localparam int BW     = 4 * DIGITS;

   typedef struct packed {
      logic [BW-1:0] bcd;
      logic          err;
   } exp_t;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              Done;
   logic              Overflow;
   logic [WIDTH-1:0]  Quotient;
   logic [BW-1:0]     BCD;
   logic              Err;
   logic              Valid;
   logic              Busy;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   hw2_quotient_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Done     (Done),
      .Overflow (Overflow),
      .Quotient (Quotient),
      .BCD      (BCD),
      .Err      (Err),
      .Valid    (Valid),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   // Reference: decimal digits by repeated division.
   function automatic exp_t model(input int unsigned q, input logic ovf);
      exp_t        e;
      int unsigned t;
      e.err = ovf;
      e.bcd = '0;
      if (ovf) begin
         e.bcd = '1;
      end else begin
         t = q;
         for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every Valid pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got BCD=%0h Err=%0b, expected no pulse", BCD, Err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (BCD !== e.bcd || Err !== e.err) begin
               bad++;
               $display("FAIL result: got BCD=%0h Err=%0b, expected BCD=%0h Err=%0b",
                        BCD, Err, e.bcd, e.err);
            end
         end
      end
   end

   // One complete job: Done low for an edge, then a rise, then wait for Valid
   // and check latency plus Busy profile.
   task automatic run_conv(input logic [WIDTH-1:0] q, input logic ovf);
      int n;
      int lat;
      @(negedge Clk);
      Done = 1'b0;
      @(negedge Clk);
      Done     = 1'b1;
      Quotient = q;
      Overflow = ovf;
      exp_q.push_back(model(q, ovf));
      lat = ovf ? 1 : WIDTH + 1;
      n = 0;
      while (1) begin
         @(negedge Clk);
         n++;
         // Inputs may change freely once the job is accepted.
         Quotient = WIDTH'($urandom);
         Overflow = 1'($urandom);
         if (n == 1) check("busy_start", 32'(Busy), 32'(!ovf));
         if (Valid === 1'b1) break;
         if (n > 40) begin
            check("valid_timeout", 32'(n), 32'(lat));
            break;
         end
      end
      check("latency", 32'(n), 32'(lat));
      check("busy_end", 32'(Busy), 32'd0);
      Done = 1'b0;
   endtask

   initial begin
      Rst      = 1'b1;
      Done     = 1'b0;
      Overflow = 1'b0;
      Quotient = '0;
      #1;
      check("rst_bcd", 32'(BCD), 32'd0);
      check("rst_err", 32'(Err), 32'd0);
      check("rst_valid", 32'(Valid), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      // Directed values
      run_conv(16'd12345, 1'b0);
      run_conv(16'hFFFF, 1'b0);
      run_conv(16'd0, 1'b0);
      run_conv(16'd9999, 1'b0);
      run_conv(16'd0, 1'b1);
      check("ovf_err", 32'(Err), 32'd1);
      run_conv(16'd42, 1'b0);
      check("err_cleared", 32'(Err), 32'd0);

      // Second rise during SHIFT is ignored; a rise at k+17 is accepted.
      begin
         int n;
         @(negedge Clk);
         Done = 1'b0;
         @(negedge Clk);
         Done     = 1'b1;
         Quotient = 16'd31415;
         Overflow = 1'b0;
         exp_q.push_back(model(16'd31415, 1'b0));
         for (n = 1; n <= 16; n++) begin
            @(negedge Clk);
            if (n == 3) Done = 1'b0;
            if (n == 5) begin
               Done     = 1'b1;
               Quotient = 16'd777;
            end
            if (n >= 1 && n <= 15) check("ignored_no_valid", 32'(Valid), 32'd0);
            if (n == 16) Done = 1'b0;
         end
         @(negedge Clk);
         check("first_valid", 32'(Valid), 32'd1);
         Done     = 1'b1;
         Quotient = 16'd8080;
         exp_q.push_back(model(16'd8080, 1'b0));
         n = 0;
         while (1) begin
            @(negedge Clk);
            n++;
            if (Valid === 1'b1 || n > 40) break;
         end
         check("third_rise_latency", 32'(n), 32'(WIDTH + 1));
         Done = 1'b0;
      end

      // Asynchronous reset in the middle of a conversion.
      begin
         @(negedge Clk);
         Done = 1'b0;
         @(negedge Clk);
         Done     = 1'b1;
         Quotient = 16'd54321;
         repeat (8) @(negedge Clk);
         #2;
         Rst = 1'b1;
         exp_q.delete();
         #1;
         check("abort_bcd", 32'(BCD), 32'd0);
         check("abort_busy", 32'(Busy), 32'd0);
         check("abort_valid", 32'(Valid), 32'd0);
         check("abort_err", 32'(Err), 32'd0);
         Done = 1'b0;
         repeat (2) @(negedge Clk);
         Rst = 1'b0;
         repeat (20) @(negedge Clk);
         check("abort_idle", 32'(Busy), 32'd0);
         run_conv(16'd2024, 1'b0);
      end

      // Done high across reset release is not a start.
      begin
         @(negedge Clk);
         Rst  = 1'b1;
         Done = 1'b1;
         @(negedge Clk);
         Rst = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            check("held_no_busy", 32'(Busy), 32'd0);
         end
         run_conv(16'd606, 1'b0);
      end

      // Randomized jobs
      for (int i = 0; i < 30; i++) begin
         run_conv(WIDTH'($urandom), ($urandom_range(0, 7) == 0));
      end

      repeat (3) @(negedge Clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
